// File: rtl/change_dispenser.sv
// Coin-change dispenser: pays an amount greedily from 10/5/1 tubes, one coin
// every other cycle, and reports any amount it could not cover.
module change_dispenser #(
  parameter int TUBE10_INIT = 8,
  parameter int TUBE5_INIT  = 8,
  parameter int TUBE1_INIT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] change_in,
  input  logic        change_valid,
  input  logic        refill,
  output logic        busy,
  output logic        coin_strobe,
  output logic [31:0] coin_out,
  output logic        done,
  output logic [31:0] shortfall,
  output logic [7:0]  tube10_cnt,
  output logic [7:0]  tube5_cnt,
  output logic [7:0]  tube1_cnt
);

  localparam logic [7:0] INIT10 = TUBE10_INIT[7:0];
  localparam logic [7:0] INIT5  = TUBE5_INIT[7:0];
  localparam logic [7:0] INIT1  = TUBE1_INIT[7:0];

  typedef enum logic [1:0] {IDLE, DISPENSE, GAP, DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_remaining, w_remaining_nxt;
  logic [31:0] r_shortfall, w_shortfall_nxt;
  logic [7:0]  r_tube10, w_tube10_nxt;
  logic [7:0]  r_tube5, w_tube5_nxt;
  logic [7:0]  r_tube1, w_tube1_nxt;

  logic        w_pick10, w_pick5, w_pick1, w_found;
  logic [31:0] w_coin;

  // Largest coin that fits the remainder and is still in stock; a pick only
  // exists when d <= remaining, so the subtraction below cannot wrap.
  assign w_pick10 = (r_tube10 != 8'd0) && (r_remaining >= 32'd10);
  assign w_pick5  = !w_pick10 && (r_tube5 != 8'd0) && (r_remaining >= 32'd5);
  assign w_pick1  = !w_pick10 && !w_pick5 && (r_tube1 != 8'd0) &&
                    (r_remaining >= 32'd1);
  assign w_found  = w_pick10 | w_pick5 | w_pick1;

  always_comb begin
    w_coin = 32'd0;
    if (w_pick10)     w_coin = 32'd10;
    else if (w_pick5) w_coin = 32'd5;
    else if (w_pick1) w_coin = 32'd1;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_shortfall_nxt = r_shortfall;
    w_tube10_nxt    = r_tube10;
    w_tube5_nxt     = r_tube5;
    w_tube1_nxt     = r_tube1;
    case (r_state)
      IDLE: begin
        if (refill) begin
          w_tube10_nxt = INIT10;
          w_tube5_nxt  = INIT5;
          w_tube1_nxt  = INIT1;
        end
        if (change_valid) begin
          w_shortfall_nxt = 32'd0;
          if (change_in != 32'd0) begin
            w_remaining_nxt = change_in;
            w_state_nxt     = DISPENSE;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      DISPENSE: begin
        if (w_found) begin
          w_remaining_nxt = r_remaining - w_coin;
          if (w_pick10) w_tube10_nxt = r_tube10 - 8'd1;
          if (w_pick5)  w_tube5_nxt  = r_tube5 - 8'd1;
          if (w_pick1)  w_tube1_nxt  = r_tube1 - 8'd1;
          w_state_nxt = GAP;
        end else begin
          w_shortfall_nxt = r_remaining;
          w_remaining_nxt = 32'd0;
          w_state_nxt     = DONE;
        end
      end
      GAP:     w_state_nxt = (r_remaining == 32'd0) ? DONE : DISPENSE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_remaining <= 32'd0;
      r_shortfall <= 32'd0;
      r_tube10    <= INIT10;
      r_tube5     <= INIT5;
      r_tube1     <= INIT1;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_shortfall <= w_shortfall_nxt;
      r_tube10    <= w_tube10_nxt;
      r_tube5     <= w_tube5_nxt;
      r_tube1     <= w_tube1_nxt;
    end
  end

  // Moore outputs: decoded from registered state only, so reset clears them at once.
  assign busy        = (r_state != IDLE);
  assign coin_strobe = (r_state == DISPENSE) && w_found;
  assign coin_out    = coin_strobe ? w_coin : 32'd0;
  assign done        = (r_state == DONE);
  assign shortfall   = r_shortfall;
  assign tube10_cnt  = r_tube10;
  assign tube5_cnt   = r_tube5;
  assign tube1_cnt   = r_tube1;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: three instances with different tube loads,
// directed and random requests checked against a greedy coin-list model.
module tb_change_dispenser;

  localparam int I10[3] = '{8, 0, 8};
  localparam int I5[3]  = '{8, 8, 8};
  localparam int I1[3]  = '{16, 16, 0};

  logic        clk;
  logic        reset;
  logic [31:0] change_in;
  logic [2:0]  cv, rf;
  logic [2:0]  bsy, stb, dn;
  logic [31:0] cout[3];
  logic [31:0] sf[3];
  logic [7:0]  c10[3], c5[3], c1[3];

  int checks = 0;
  int errors = 0;
  int m10[3], m5[3], m1[3], msf[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    change_dispenser #(.TUBE10_INIT(I10[g]), .TUBE5_INIT(I5[g]), .TUBE1_INIT(I1[g])) u_dut (
      .clk(clk), .reset(reset), .change_in(change_in), .change_valid(cv[g]),
      .refill(rf[g]), .busy(bsy[g]), .coin_strobe(stb[g]), .coin_out(cout[g]),
      .done(dn[g]), .shortfall(sf[g]), .tube10_cnt(c10[g]), .tube5_cnt(c5[g]),
      .tube1_cnt(c1[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init(input int i);
    m10[i] = I10[i]; m5[i] = I5[i]; m1[i] = I1[i];
  endtask

  task automatic chk_tubes(input int i, input string tag);
    chk($sformatf("d%0d %s tube10", i, tag), {24'd0, c10[i]}, m10[i]);
    chk($sformatf("d%0d %s tube5", i, tag),  {24'd0, c5[i]},  m5[i]);
    chk($sformatf("d%0d %s tube1", i, tag),  {24'd0, c1[i]},  m1[i]);
  endtask

  // One request on instance idx. Options: refill alongside the strobe, a
  // stray second request in cycle 2, a refill pulse in a busy cycle, and a
  // reset after strobe number rst_after.
  task automatic run_req(input int idx, input int amt, input bit with_refill,
                         input bit inject, input int refill_busy_cyc, input int rst_after);
    int coins[$];
    int rem, n, dcyc;
    if (with_refill) model_init(idx);
    rem = amt;
    forever begin
      if (rem >= 10 && m10[idx] > 0)     begin coins.push_back(10); rem -= 10; m10[idx]--; end
      else if (rem >= 5 && m5[idx] > 0)  begin coins.push_back(5);  rem -= 5;  m5[idx]--;  end
      else if (rem >= 1 && m1[idx] > 0)  begin coins.push_back(1);  rem -= 1;  m1[idx]--;  end
      else break;
    end
    n = coins.size();
    msf[idx] = rem;
    dcyc = 2 * n + 1 + ((rem > 0) ? 1 : 0);

    @(negedge clk);
    change_in = amt; cv[idx] = 1'b1; rf[idx] = with_refill;
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      cv[idx] = 1'b0; rf[idx] = 1'b0;
      begin
        bit es;
        int ec;
        es = (c % 2 == 1) && ((c + 1) / 2 <= n);
        ec = es ? coins[(c - 1) / 2] : 0;
        chk($sformatf("d%0d amt%0d c%0d strobe", idx, amt, c), {31'd0, stb[idx]}, {31'd0, es});
        chk($sformatf("d%0d amt%0d c%0d coin", idx, amt, c), cout[idx], ec);
        chk($sformatf("d%0d amt%0d c%0d done", idx, amt, c), {31'd0, dn[idx]}, (c == dcyc) ? 1 : 0);
        chk($sformatf("d%0d amt%0d c%0d busy", idx, amt, c), {31'd0, bsy[idx]}, 1);
      end
      if (inject && c == 2) begin change_in = 5; cv[idx] = 1'b1; end
      if (c == refill_busy_cyc) rf[idx] = 1'b1;
      if (rst_after > 0 && c == 2 * rst_after) begin
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin model_init(i); msf[i] = 0; end
        chk("rst busy", {31'd0, bsy[idx]}, 0);
        chk("rst strobe", {31'd0, stb[idx]}, 0);
        chk("rst coin", cout[idx], 0);
        chk("rst done", {31'd0, dn[idx]}, 0);
        chk("rst shortfall", sf[idx], 0);
        chk_tubes(idx, "rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("post-rst k%0d strobe", k), {31'd0, stb[idx]}, 0);
          chk($sformatf("post-rst k%0d done", k), {31'd0, dn[idx]}, 0);
          chk($sformatf("post-rst k%0d busy", k), {31'd0, bsy[idx]}, 0);
        end
        chk_tubes(idx, "post-rst");
        return;
      end
    end
    @(negedge clk);
    cv[idx] = 1'b0; rf[idx] = 1'b0;
    chk($sformatf("d%0d amt%0d idle busy", idx, amt), {31'd0, bsy[idx]}, 0);
    chk($sformatf("d%0d amt%0d idle done", idx, amt), {31'd0, dn[idx]}, 0);
    chk($sformatf("d%0d amt%0d shortfall", idx, amt), sf[idx], msf[idx]);
    chk_tubes(idx, $sformatf("amt%0d", amt));
  endtask

  task automatic do_refill(input int idx);
    @(negedge clk);
    rf[idx] = 1'b1;
    @(negedge clk);
    rf[idx] = 1'b0;
    model_init(idx);
    chk_tubes(idx, "refill");
    chk($sformatf("d%0d refill busy", idx), {31'd0, bsy[idx]}, 0);
  endtask

  initial begin
    reset = 1'b1; change_in = 32'd0; cv = 3'b0; rf = 3'b0;
    for (int i = 0; i < 3; i++) begin model_init(i); msf[i] = 0; end
    #2 reset = 1'b0;
    #20;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset busy", i), {31'd0, bsy[i]}, 0);
      chk($sformatf("d%0d reset strobe", i), {31'd0, stb[i]}, 0);
      chk($sformatf("d%0d reset coin", i), cout[i], 0);
      chk($sformatf("d%0d reset done", i), {31'd0, dn[i]}, 0);
      chk($sformatf("d%0d reset shortfall", i), sf[i], 0);
      chk_tubes(i, "reset");
    end
    @(negedge clk);
    reset = 1'b1;

    run_req(0, 16, 0, 0, 0, 0);    // 10,5,1 -> 7/7/15
    run_req(1, 22, 0, 0, 0, 0);    // no tens: 5,5,5,5,1,1
    run_req(2, 3, 0, 0, 0, 0);     // no ones: shortfall 3
    run_req(0, 0, 0, 0, 0, 0);     // immediate done
    run_req(0, 22, 0, 1, 0, 0);    // stray second request ignored
    run_req(0, 22, 0, 0, 0, 2);    // reset after second strobe
    run_req(0, 16, 0, 0, 3, 0);    // refill while busy ignored
    run_req(0, 200, 0, 0, 0, 0);   // depletes every tube
    do_refill(0);
    run_req(1, 200, 0, 0, 0, 0);
    run_req(1, 7, 1, 0, 0, 0);     // refill and request in the same edge
    for (int r = 0; r < 12; r++) begin
      int idx, amt;
      bit wr;
      idx = $urandom_range(0, 2);
      amt = $urandom_range(0, 60);
      wr  = ($urandom_range(0, 3) == 0);
      run_req(idx, amt, wr, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
